// File: rtl/sr_cmd_gen.sv
// -----------------------------------------------------------------------------
// sr_cmd_gen
//   Turns two raw, asynchronous request levels (set / clear) into clean,
//   mutually exclusive command pulses for a downstream SR flip-flop.
//   Each request is synchronized (2 flops), debounced (DEB_CYCLES stable
//   cycles) and edge-detected; a rising filtered level is an event.  A small
//   FSM turns an event into a PULSE_LEN-cycle s or r pulse, flags
//   simultaneous set/clear events (conflict) and discards events that arrive
//   while a pulse is running (drop).
//
// Parameters
//   DEB_CYCLES  stable synced cycles needed to accept a level change (2..255)
//   PULSE_LEN   width of each s/r pulse in cycles (1..15)
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   asynchronous reset, active low
//   set_req   in   raw set request level
//   clr_req   in   raw clear request level
//   s         out  set command, registered
//   r         out  reset command, registered
//   busy      out  high while a command pulse is in progress, registered
//   conflict  out  one-cycle pulse: set and clear events in the same idle cycle
//   drop      out  one-cycle pulse: event discarded because a pulse was running
// -----------------------------------------------------------------------------
module sr_cmd_gen #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned PULSE_LEN  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict,
  output logic drop
);

  localparam logic [7:0] DEB_TARGET = 8'(DEB_CYCLES);
  localparam logic [3:0] PULSE_LAST = 4'(PULSE_LEN - 1);

  // Channel index: 0 = set, 1 = clear.
  localparam int CH_SET = 0;
  localparam int CH_CLR = 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SET_PULSE = 2'd1,
    CLR_PULSE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning: synchronizer, debounce, rising-edge detect
  // ---------------------------------------------------------------------------
  logic [1:0] w_raw;
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] r_filt;
  logic [1:0] r_filt_d;
  logic [7:0] r_deb_cnt [2];
  logic [1:0] w_evt;

  assign w_raw = {clr_req, set_req};

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of its neighbours (the two sync
  // stages would otherwise collapse into one).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_filt   <= '0;
      r_filt_d <= '0;
      for (int i = 0; i < 2; i++) begin
        r_deb_cnt[i] <= '0;
      end
    end else begin
      r_sync1  <= w_raw;
      r_sync2  <= r_sync1;
      r_filt_d <= r_filt;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] + 8'd1 == DEB_TARGET) begin
          // Stable long enough: accept the new level and restart counting.
          r_filt[i]    <= r_sync2[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 8'd1;
        end
      end
    end
  end

  // Only a 0->1 change of the filtered level is an event.
  assign w_evt = r_filt & ~r_filt_d;

  // ---------------------------------------------------------------------------
  // Command FSM
  // ---------------------------------------------------------------------------
  state_t     r_state;
  state_t     w_state_nx;
  logic [3:0] r_pcnt;
  logic [3:0] w_pcnt_nx;
  logic       r_s;
  logic       r_r;
  logic       r_busy;
  logic       r_conflict;
  logic       r_drop;
  logic       w_s_nx;
  logic       w_r_nx;
  logic       w_busy_nx;
  logic       w_conflict_nx;
  logic       w_drop_nx;

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nx    = r_state;
    w_pcnt_nx     = r_pcnt;
    w_s_nx        = 1'b0;
    w_r_nx        = 1'b0;
    w_busy_nx     = 1'b0;
    w_conflict_nx = 1'b0;
    w_drop_nx     = 1'b0;
    case (r_state)
      IDLE: begin
        w_pcnt_nx = '0;
        if (w_evt[CH_SET] && w_evt[CH_CLR]) begin
          w_conflict_nx = 1'b1;
        end else if (w_evt[CH_SET]) begin
          w_state_nx = SET_PULSE;
          w_s_nx     = 1'b1;
          w_busy_nx  = 1'b1;
        end else if (w_evt[CH_CLR]) begin
          w_state_nx = CLR_PULSE;
          w_r_nx     = 1'b1;
          w_busy_nx  = 1'b1;
        end
      end
      SET_PULSE, CLR_PULSE: begin
        // Events while a pulse runs are discarded, never queued.
        w_drop_nx = |w_evt;
        if (r_pcnt == PULSE_LAST) begin
          w_state_nx = IDLE;
          w_pcnt_nx  = '0;
        end else begin
          w_pcnt_nx = r_pcnt + 4'd1;
          w_s_nx    = (r_state == SET_PULSE);
          w_r_nx    = (r_state == CLR_PULSE);
          w_busy_nx = 1'b1;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_pcnt_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_pcnt     <= '0;
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_busy     <= 1'b0;
      r_conflict <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_pcnt     <= w_pcnt_nx;
      r_s        <= w_s_nx;
      r_r        <= w_r_nx;
      r_busy     <= w_busy_nx;
      r_conflict <= w_conflict_nx;
      r_drop     <= w_drop_nx;
    end
  end

  assign s        = r_s;
  assign r        = r_r;
  assign busy     = r_busy;
  assign conflict = r_conflict;
  assign drop     = r_drop;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// -----------------------------------------------------------------------------
// tb_sr_cmd_gen
//   Directed bench for sr_cmd_gen with DEB_CYCLES=4, PULSE_LEN=2.
//   Inputs change just after a rising edge; "edge k" is the first rising edge
//   that sees a new raw level.  Outputs are sampled 1 ns after each edge.
// -----------------------------------------------------------------------------
module tb_sr_cmd_gen;

  logic clk = 1'b0;
  logic rst;
  logic set_req;
  logic clr_req;
  logic s;
  logic r;
  logic busy;
  logic conflict;
  logic drop;

  int n_checks = 0;
  int n_errors = 0;

  sr_cmd_gen #(
    .DEB_CYCLES(4),
    .PULSE_LEN (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .set_req (set_req),
    .clr_req (clr_req),
    .s       (s),
    .r       (r),
    .busy    (busy),
    .conflict(conflict),
    .drop    (drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    set_req = 1'b0;
    clr_req = 1'b0;
    repeat (n) step();
  endtask

  int run_s;
  int run_r;
  int overlap;
  int hold_s;
  int hold_c;

  initial begin
    rst     = 1'b0;
    set_req = 1'b0;
    clr_req = 1'b0;
    repeat (2) step();

    // Reset state
    check("rst_s", s, 0);
    check("rst_r", r, 0);
    check("rst_busy", busy, 0);
    check("rst_conflict", conflict, 0);
    check("rst_drop", drop, 0);
    rst = 1'b1;
    step();
    check("idle_s", s, 0);

    // Set request: s high after edges k+6, k+7 only
    set_req = 1'b1;
    for (int e = 0; e <= 9; e++) begin
      step();
      check("set_s", s, (e == 6 || e == 7) ? 1 : 0);
      check("set_busy", busy, (e == 6 || e == 7) ? 1 : 0);
      check("set_r", r, 0);
      check("set_conflict", conflict, 0);
      check("set_drop", drop, 0);
    end
    // Releasing the request is not an event
    set_req = 1'b0;
    for (int e = 0; e <= 11; e++) begin
      step();
      check("fall_s", s, 0);
      check("fall_r", r, 0);
    end
    check("fall_filt_set", dut.r_filt[0], 0);

    // Glitch: 3 synced cycles high is not enough
    clr_req = 1'b1;
    for (int e = 0; e <= 12; e++) begin
      if (e == 3) clr_req = 1'b0;
      step();
      check("glitch_r", r, 0);
      check("glitch_busy", busy, 0);
      check("glitch_filt", dut.r_filt[1], 0);
    end

    // Boundary: exactly 4 synced cycles high qualifies
    clr_req = 1'b1;
    for (int e = 0; e <= 9; e++) begin
      if (e == 4) clr_req = 1'b0;
      step();
      check("deb4_r", r, (e == 6 || e == 7) ? 1 : 0);
      check("deb4_s", s, 0);
    end
    idle(12);

    // Simultaneous set and clear events: conflict only
    set_req = 1'b1;
    clr_req = 1'b1;
    for (int e = 0; e <= 9; e++) begin
      step();
      check("conf_flag", conflict, (e == 6) ? 1 : 0);
      check("conf_s", s, 0);
      check("conf_r", r, 0);
      check("conf_busy", busy, 0);
      check("conf_drop", drop, 0);
    end
    idle(12);

    // Clear event during the s pulse is dropped
    set_req = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      if (e == 1) clr_req = 1'b1;
      step();
      check("drop_s", s, (e == 6 || e == 7) ? 1 : 0);
      check("drop_flag", drop, (e == 7) ? 1 : 0);
      check("drop_r", r, 0);
      check("drop_conflict", conflict, 0);
    end
    idle(12);

    // Asynchronous reset mid pulse, then re-qualification
    set_req = 1'b1;
    repeat (7) step();
    check("pre_rst_s", s, 1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_s", s, 0);
    check("async_rst_busy", busy, 0);
    step();
    check("in_rst_filt", dut.r_filt[0], 0);
    rst = 1'b1;
    for (int e = 0; e <= 9; e++) begin
      step();
      check("rearm_s", s, (e == 6 || e == 7) ? 1 : 0);
      check("rearm_r", r, 0);
    end
    idle(12);

    // Random toggling: s and r never together, every pulse 2 cycles
    run_s   = 0;
    run_r   = 0;
    overlap = 0;
    hold_s  = 0;
    hold_c  = 0;
    for (int i = 0; i < 10040; i++) begin
      if (i < 10000) begin
        if (hold_s == 0) begin
          set_req = ~set_req;
          hold_s  = $urandom_range(1, 12);
        end
        if (hold_c == 0) begin
          clr_req = ~clr_req;
          hold_c  = $urandom_range(1, 12);
        end
        hold_s--;
        hold_c--;
      end else begin
        set_req = 1'b0;
        clr_req = 1'b0;
      end
      step();
      if (s && r) overlap++;
      if (s) run_s++;
      else if (run_s != 0) begin
        check("rand_s_width", run_s, 2);
        run_s = 0;
      end
      if (r) run_r++;
      else if (run_r != 0) begin
        check("rand_r_width", run_r, 2);
        run_r = 0;
      end
    end
    check("rand_overlap", overlap, 0);
    check("rand_tail_s", run_s, 0);
    check("rand_tail_r", run_r, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
